iter_csa_multiplier: RTL and testbench



---
 rtl/iter_mult_pkg.sv | 37 +++
 rtl/csa_compressor_4to2.sv | 33 +++
 rtl/iter_csa_multiplier.sv | 142 ++++++++++++++
 tb/tb_iter_csa_multiplier.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module : iter_mult_pkg
// Brief  : Shared types and elaboration helpers for the iterative carry-save
//          multiplier: FSM state encoding, counter-width helper and the
//          operand/slice width legality check.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package iter_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ceil(log2(n)), never below 1 so that a single-slice build still has a
    // legal one-bit slice index.
    function automatic int cnt_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Operand a must split into whole slices.
    function automatic bit chunk_ok(input int a_width, input int chunk);
        return (chunk > 0) && (a_width >= chunk) && ((a_width % chunk) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_compressor_4to2.sv
`default_nettype none
// ============================================================================
// Module : csa_compressor_4to2
// Brief  : Purely combinational 4:2 compressor built from two 3:2 carry-save
//          stages. sum + carry == x0 + x1 + x2 + x3 (mod 2^WIDTH); the carry
//          output is already shifted into its weight.
// Ports  : x0..x3  in   WIDTH  addends
//          sum     out  WIDTH  bitwise sum vector
//          carry   out  WIDTH  carry vector, pre-shifted left by one
// Rev    : 1.0  initial release
// ============================================================================
module csa_compressor_4to2 #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    logic [WIDTH-1:0] w_s1;
    logic [WIDTH-1:0] w_c1;

    // First stage folds x0..x2, second stage folds its result with x3.
    assign w_s1  = x0 ^ x1 ^ x2;
    assign w_c1  = ((x0 & x1) | (x0 & x2) | (x1 & x2)) << 1;
    assign sum   = w_s1 ^ w_c1 ^ x3;
    assign carry = ((w_s1 & w_c1) | (w_s1 & x3) | (w_c1 & x3)) << 1;

endmodule
`default_nettype wire

// File: rtl/iter_csa_multiplier.sv
`default_nettype none
// ============================================================================
// Module : iter_csa_multiplier
// Brief  : Multi-cycle multiplier. Operand a is consumed CHUNK bits per cycle,
//          most-significant slice first; each slice partial product (a
//          carry-save pair) is merged into the shifted carry-save accumulator
//          by a 4:2 compressor, and one final carry-propagate add forms the
//          product. Signed/unsigned modes, valid/ready on both sides.
// Ports  : clk, rst            clock, synchronous active-high reset
//          in_valid/in_ready   operand handshake
//          a [A_WIDTH], b [B_WIDTH], signed_mode   operands and mode
//          out_valid/out_ready result handshake (backpressure honoured)
//          prod [A_WIDTH+B_WIDTH]  product modulo 2^(A_WIDTH+B_WIDTH)
//          busy                high while an operation is in flight
// Rev    : 1.0  initial release
// ============================================================================
module iter_csa_multiplier
    import iter_mult_pkg::*;
#(
    parameter int A_WIDTH = 64,
    parameter int B_WIDTH = 64,
    parameter int CHUNK   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    input  logic                       signed_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [A_WIDTH+B_WIDTH-1:0] prod,
    output logic                       busy
);

    localparam int NUM_CHUNKS = A_WIDTH / CHUNK;
    localparam int P_WIDTH    = A_WIDTH + B_WIDTH;
    localparam int CNT_W      = cnt_width(NUM_CHUNKS);

    localparam logic [CNT_W-1:0]   c_top_idx   = CNT_W'(NUM_CHUNKS - 1);
    // b is split into a low and a high part so the partial product leaves the
    // generator as a genuine two-vector carry-save pair.
    localparam logic [P_WIDTH-1:0] c_b_lo_mask = (P_WIDTH'(1) << (B_WIDTH / 2)) - P_WIDTH'(1);

    if (!chunk_ok(A_WIDTH, CHUNK)) begin : g_bad_chunk
        $error("iter_csa_multiplier: A_WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t               r_state;
    state_t               w_next_state;
    logic [A_WIDTH-1:0]   r_a;
    logic [B_WIDTH-1:0]   r_b;
    logic                 r_signed;
    logic [P_WIDTH-1:0]   r_sum;
    logic [P_WIDTH-1:0]   r_carry;
    logic [CNT_W-1:0]     r_idx;
    logic [P_WIDTH-1:0]   r_prod;

    logic                 w_fire_in;
    logic                 w_last;
    logic [CHUNK-1:0]     w_slice;
    logic                 w_slice_sign;
    logic [P_WIDTH-1:0]   w_slice_ext;
    logic [P_WIDTH-1:0]   w_b_ext;
    logic [P_WIDTH-1:0]   w_pp_a;
    logic [P_WIDTH-1:0]   w_pp_b;
    logic [P_WIDTH-1:0]   w_cs_sum;
    logic [P_WIDTH-1:0]   w_cs_carry;

    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign prod      = r_prod;
    assign w_fire_in = in_valid && in_ready;
    assign w_last    = (r_idx == '0);

    // r_a is shifted left each RUN cycle, so the current slice is always the
    // top CHUNK bits. Only the most-significant slice carries the sign.
    assign w_slice      = r_a[A_WIDTH-1 -: CHUNK];
    assign w_slice_sign = r_signed && (r_idx == c_top_idx) && w_slice[CHUNK-1];
    assign w_slice_ext  = {{(P_WIDTH-CHUNK){w_slice_sign}}, w_slice};
    assign w_b_ext      = {{A_WIDTH{r_signed && r_b[B_WIDTH-1]}}, r_b};
    assign w_pp_a       = w_slice_ext * (w_b_ext & c_b_lo_mask);
    assign w_pp_b       = w_slice_ext * (w_b_ext & ~c_b_lo_mask);

    csa_compressor_4to2 #(
        .WIDTH (P_WIDTH)
    ) u_compress (
        .x0    (r_sum << CHUNK),
        .x1    (r_carry << CHUNK),
        .x2    (w_pp_a),
        .x3    (w_pp_b),
        .sum   (w_cs_sum),
        .carry (w_cs_carry)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (in_valid) w_next_state = RUN;
            RUN:  if (w_last)   w_next_state = DONE;
            DONE: if (out_ready) w_next_state = in_valid ? RUN : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_sum    <= '0;
            r_carry  <= '0;
            r_idx    <= '0;
            r_prod   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_fire_in) begin
                r_a      <= a;
                r_b      <= b;
                r_signed <= signed_mode;
                r_sum    <= '0;
                r_carry  <= '0;
                r_idx    <= c_top_idx;
            end else if (r_state == RUN) begin
                r_sum   <= w_cs_sum;
                r_carry <= w_cs_carry;
                r_a     <= r_a << CHUNK;
                if (w_last) begin
                    // Resolve the carry-save pair while entering DONE.
                    r_prod <= w_cs_sum + w_cs_carry;
                end else begin
                    r_idx <= r_idx - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iter_csa_multiplier.sv
`default_nettype none
// ============================================================================
// Module : tb_iter_csa_multiplier
// Brief  : Self-checking bench for iter_csa_multiplier. One instance in the
//          default 64x64/32 configuration and one at 16x8/4; directed vectors
//          with hand-computed products plus a random sweep on the small
//          instance against a plain multiply model.
// Ports  : none
// Rev    : 1.0  initial release
// ============================================================================
module tb_iter_csa_multiplier;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Default configuration instance
    logic          big_in_valid, big_in_ready, big_sm, big_out_valid, big_out_ready, big_busy;
    logic [63:0]   big_a, big_b;
    logic [127:0]  big_prod;

    // Small configuration instance
    logic          sml_in_valid, sml_in_ready, sml_sm, sml_out_valid, sml_out_ready, sml_busy;
    logic [15:0]   sml_a;
    logic [7:0]    sml_b;
    logic [23:0]   sml_prod;

    iter_csa_multiplier #(
        .A_WIDTH (64),
        .B_WIDTH (64),
        .CHUNK   (32)
    ) u_big (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (big_in_valid),
        .in_ready    (big_in_ready),
        .a           (big_a),
        .b           (big_b),
        .signed_mode (big_sm),
        .out_valid   (big_out_valid),
        .out_ready   (big_out_ready),
        .prod        (big_prod),
        .busy        (big_busy)
    );

    iter_csa_multiplier #(
        .A_WIDTH (16),
        .B_WIDTH (8),
        .CHUNK   (4)
    ) u_sml (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (sml_in_valid),
        .in_ready    (sml_in_ready),
        .a           (sml_a),
        .b           (sml_b),
        .signed_mode (sml_sm),
        .out_valid   (sml_out_valid),
        .out_ready   (sml_out_ready),
        .prod        (sml_prod),
        .busy        (sml_busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_sml(input logic [15:0] a, input logic [7:0] b, input logic sm);
        logic signed [23:0] ea;
        logic signed [23:0] eb;
        ea = sm ? {{8{a[15]}}, a} : {8'h00, a};
        eb = sm ? {{16{b[7]}}, b} : {16'h0000, b};
        return ea * eb;
    endfunction

    // Issue one operation on the big instance and wait for out_valid;
    // leaves the result pending (out_ready low).
    task automatic op_big(input logic [63:0] a, input logic [63:0] b, input logic sm,
                          input logic [127:0] exp, input string tag);
        int lat;
        @(negedge clk);
        check({tag, " in_ready"}, big_in_ready, 1);
        big_in_valid = 1'b1;
        big_a        = a;
        big_b        = b;
        big_sm       = sm;
        @(negedge clk);
        big_in_valid = 1'b0;
        big_a        = '0;
        big_b        = '0;
        lat = 1;
        while (!big_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 3);
        check({tag, " prod"}, big_prod, exp);
    endtask

    task automatic drain_big(input string tag);
        big_out_ready = 1'b1;
        @(negedge clk);
        big_out_ready = 1'b0;
        check({tag, " out_valid after fire"}, big_out_valid, 0);
    endtask

    task automatic op_sml(input logic [15:0] a, input logic [7:0] b, input logic sm,
                          input logic [23:0] exp, input string tag);
        int lat;
        @(negedge clk);
        sml_in_valid = 1'b1;
        sml_a        = a;
        sml_b        = b;
        sml_sm       = sm;
        @(negedge clk);
        sml_in_valid = 1'b0;
        sml_a        = '0;
        sml_b        = '0;
        lat = 1;
        while (!sml_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 5);
        check({tag, " prod"}, sml_prod, exp);
        sml_out_ready = 1'b1;
        @(negedge clk);
        sml_out_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]  bb_a [3];
        logic [63:0]  bb_b [3];
        logic [127:0] bb_p [3];
        int           lat;
        int           seen;
        logic [15:0]  ra;
        logic [7:0]   rb;
        logic         rs;

        bb_a = '{64'd3, 64'd7, 64'd0};
        bb_b = '{64'd5, 64'd9, 64'hDEAD_BEEF};
        bb_p = '{128'd15, 128'd63, 128'd0};

        rst = 1'b1;
        big_in_valid = 1'b0; big_out_ready = 1'b0; big_a = '0; big_b = '0; big_sm = 1'b0;
        sml_in_valid = 1'b0; sml_out_ready = 1'b0; sml_a = '0; sml_b = '0; sml_sm = 1'b0;
        repeat (3) @(negedge clk);

        check("reset in_ready",  big_in_ready, 1);
        check("reset out_valid", big_out_valid, 0);
        check("reset busy",      big_busy, 0);
        check("reset prod",      big_prod, 0);
        check("reset sml prod",  sml_prod, 0);
        rst = 1'b0;

        // Unsigned all-ones squared
        op_big(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
               128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "u_ones");
        check("u_ones busy in DONE", big_busy, 1);
        drain_big("u_ones");

        // Signed corners
        op_big(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'd1, "s_m1xm1");
        drain_big("s_m1xm1");
        op_big(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
               128'h0000_0000_0000_0000_8000_0000_0000_0000, "s_minxm1");
        drain_big("s_minxm1");

        // Backpressure: result must hold for 5 cycles
        op_big(64'd12345, 64'd67890, 1'b0, 128'd838102050, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp hold out_valid", big_out_valid, 1);
            check("bp hold prod",      big_prod, 128'd838102050);
            check("bp hold in_ready",  big_in_ready, 0);
        end
        big_out_ready = 1'b1;
        #1;
        check("bp in_ready follows out_ready", big_in_ready, 1);
        @(negedge clk);
        big_out_ready = 1'b0;
        check("bp out_valid after fire", big_out_valid, 0);
        check("bp in_ready after fire",  big_in_ready, 1);
        check("bp busy after fire",      big_busy, 0);

        // Reset in the cycle after accept aborts the operation
        @(negedge clk);
        big_in_valid = 1'b1; big_a = 64'd5; big_b = 64'd6; big_sm = 1'b0;
        @(negedge clk);
        big_in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst out_valid", big_out_valid, 0);
        check("rst in_ready",  big_in_ready, 1);
        check("rst prod",      big_prod, 0);
        check("rst busy",      big_busy, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (big_out_valid) seen++;
        end
        check("rst no stale result", seen, 0);
        op_big(64'd5, 64'd7, 1'b0, 128'd35, "post_rst");
        drain_big("post_rst");

        // Back-to-back with in_valid and out_ready held high
        @(negedge clk);
        big_out_ready = 1'b1;
        big_in_valid  = 1'b1;
        big_sm        = 1'b0;
        big_a         = bb_a[0];
        big_b         = bb_b[0];
        for (int i = 0; i < 3; i++) begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!big_out_valid && lat < 20);
            check("b2b spacing",  lat, 3);
            check("b2b prod",     big_prod, bb_p[i]);
            check("b2b in_ready", big_in_ready, 1);
            if (i < 2) begin
                big_a = bb_a[i+1];
                big_b = bb_b[i+1];
            end else begin
                big_in_valid = 1'b0;
            end
        end
        @(negedge clk);
        big_out_ready = 1'b0;
        check("b2b idle after last", big_out_valid, 0);

        // Small configuration
        op_sml(16'hFED4, 8'h80, 1'b1, 24'd38400, "sml_signed");
        op_sml(16'hFFFF, 8'hFF, 1'b0, 24'hFEFF01, "sml_unsigned");
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            op_sml(ra, rb, rs, ref_sml(ra, rb, rs), "sml_rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
